// File: rtl/reg_mask_encoder_if.sv
// Handshake bundle between a mask producer and the register index consumer.
// The producer loads a 32-bit bitmap; the encoder streams back one index per handshake.
interface reg_mask_encoder_if;
    logic [31:0] mask_in;
    logic        load;
    logic        load_ready;
    logic        abort;
    logic [4:0]  idx;
    logic        idx_valid;
    logic        idx_ready;
    logic        last;
    logic        done;
    logic        busy;

    modport master (
        output mask_in, load, abort, idx_ready,
        input  load_ready, idx, idx_valid, last, done, busy
    );

    modport slave (
        input  mask_in, load, abort, idx_ready,
        output load_ready, idx, idx_valid, last, done, busy
    );
endinterface

// File: rtl/reg_mask_encoder.sv
// Register bitmap to index stream encoder for load/store-multiple sequencing.
// Emits each set bit of a captured mask once, in ascending or descending order.
module reg_mask_encoder #(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    reg_mask_encoder_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic        done_q, done_d;
    logic [4:0]  sel;
    logic        one_left;
    logic        emit;

    // Later matches win, so the scan direction picks lowest or highest bit.
    always_comb begin
        sel = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 32; i++) begin
                if (pending_q[i]) sel = 5'(i);
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (pending_q[i]) sel = 5'(i);
            end
        end
    end

    assign one_left = (pending_q != '0) &&
                      ((pending_q & (pending_q - 32'd1)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        if (bus.abort) begin
            state_d   = IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        if (bus.mask_in != '0) begin
                            pending_d = bus.mask_in;
                            state_d   = EMIT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.idx_ready) begin
                        pending_d = pending_q & ~(32'd1 << sel);
                        if (one_left) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign emit = (state_q == EMIT);

    always_comb begin
        bus.load_ready = !emit;
        bus.busy       = emit;
        bus.idx_valid  = emit;
        bus.idx        = emit ? sel : 5'd0;
        bus.last       = emit && one_left;
        bus.done       = done_q;
    end

endmodule
